// File: rtl/float2int16_arbiter_pkg.sv
// Shared types and constants for the float32 -> int16 arbitrated converter.
package f2i_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    OUT
  } state_t;

  localparam int          EXP_BIAS  = 127;
  localparam logic [15:0] INT16_MAX = 16'h7FFF;
  localparam logic [15:0] INT16_MIN = 16'h8000;
  localparam int          MANT_KEEP = 14;

endpackage

// File: rtl/float32_to_int16_sat.sv
// Combinational IEEE-754 single to int16 conversion, truncating toward zero,
// with saturation (or exponent forcing) and NaN zeroing.
module float32_to_int16_sat
  import f2i_pkg::*;
#(
  parameter int SAT_EN = 1
) (
  input  logic [31:0] value,
  output logic [15:0] result,
  output logic        sat
);

  logic              sign;
  logic [7:0]        exp_f;
  logic [22:0]       mant;
  logic signed [8:0] e;
  logic [3:0]        shamt;
  logic [14:0]       mag;

  function automatic logic [15:0] apply_sign(input logic neg, input logic [14:0] m);
    logic [15:0] ext;
    ext = {1'b0, m};
    return neg ? 16'(-ext) : ext;
  endfunction

  assign sign  = value[31];
  assign exp_f = value[30:23];
  assign mant  = value[22:0];
  assign e     = 9'(int'({1'b0, exp_f}) - EXP_BIAS);

  always_comb begin
    result = '0;
    sat    = 1'b0;
    shamt  = '0;
    mag    = '0;
    if (exp_f == 8'hFF && mant != '0) begin
      sat = 1'b1;
    end else if (e < 0) begin
      result = '0;
    end else if (e > MANT_KEEP && SAT_EN != 0) begin
      result = sign ? INT16_MIN : INT16_MAX;
      sat    = 1'b1;
    end else begin
      // Out-of-range inputs without saturation keep only the top mantissa bits.
      if (e > MANT_KEEP) begin
        shamt = '0;
        sat   = 1'b1;
      end else begin
        shamt = 4'(MANT_KEEP - int'(e));
      end
      mag    = {1'b1, mant[22 -: MANT_KEEP]} >> shamt;
      result = apply_sign(sign, mag);
    end
  end

endmodule

// File: rtl/float2int16_arbiter.sv
// Round-robin arbiter sharing one float32 -> int16 converter between
// NUM_REQ producers; one result at a time on a valid/ready output.
module float2int16_arbiter
  import f2i_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SAT_EN  = 1,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [32*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [15:0]          o_out_data,
  output logic [IDW-1:0]       o_out_id,
  output logic                 o_out_sat,
  output logic                 o_busy
);

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, rr_nxt, gnt_idx, cand;
  logic [IDW:0]   sum;
  logic           gnt_any;
  logic [31:0]    sel_word;
  logic [31:0]    word_p0;
  logic [IDW-1:0] id_p0;
  logic [15:0]    conv_data;
  logic           conv_sat;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      cand = sum[IDW-1:0];
      if (!gnt_any && i_req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) sel_word = i_req_data[32*i +: 32];
    end
  end

  assign rr_nxt = (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + IDW'(1);
  assign o_busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    o_req_ready = '0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          o_req_ready[gnt_idx] = i_rst_n;
          state_nxt            = CONV;
        end
      end
      CONV:    state_nxt = OUT;
      OUT:     if (i_out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
      o_out_id    <= '0;
      o_out_sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && gnt_any) rr_ptr <= rr_nxt;
      if (state == CONV) begin
        o_out_data  <= conv_data;
        o_out_id    <= id_p0;
        o_out_sat   <= conv_sat;
        o_out_valid <= 1'b1;
      end else if (state == OUT && i_out_ready) begin
        o_out_valid <= 1'b0;
      end
    end
  end

  // p0: granted sample captured for the conversion cycle
  always_ff @(posedge i_clk) begin
    if (state == IDLE && gnt_any) begin
      word_p0 <= sel_word;
      id_p0   <= gnt_idx;
    end
  end

  float32_to_int16_sat #(
    .SAT_EN (SAT_EN)
  ) u_conv (
    .value  (word_p0),
    .result (conv_data),
    .sat    (conv_sat)
  );

endmodule

// File: tb/tb_float2int16_arbiter.sv
// Randomized bench for float2int16_arbiter with a real-arithmetic reference
// model and a round-robin scoreboard.
module tb_float2int16_arbiter;

  localparam int N   = 2;
  localparam int IDW = 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [32*N-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [IDW-1:0]   out_id;
  logic             out_sat;
  logic             busy;

  always #5 clk = ~clk;

  float2int16_arbiter #(
    .NUM_REQ (N),
    .SAT_EN  (1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_id    (out_id),
    .o_out_sat   (out_sat),
    .o_busy      (busy)
  );

  typedef struct {
    logic [15:0] d;
    int          id;
    logic        s;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          mode = 0;
  int          rr = 0;
  int          gnt_cyc = 0;
  int          bp_cnt = 0;
  int          tbl_idx = 0;
  int          dir_acc = 0;
  bit          pend = 0;
  bit [N-1:0]  granted = '0;
  bit          val_v [N];
  logic [31:0] val_d [N];
  exp_t        q[$];

  logic [31:0] tbl     [9] = '{32'h3F800000, 32'h43000000, 32'hC0200000,
                              32'h3F000000, 32'h80000000, 32'h46FFFE00,
                              32'h47000000, 32'hFF800000, 32'h7FC00000};
  logic [15:0] tbl_exp [9] = '{16'h0001, 16'h0080, 16'hFFFE,
                              16'h0000, 16'h0000, 16'h7FFF,
                              16'h7FFF, 16'h8000, 16'h0000};
  logic        tbl_sat [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Value-level reference: decode to a real number, then truncate or clamp.
  function automatic void ref_conv(input logic [31:0] f, output logic [15:0] r, output logic s);
    real         m;
    int          t;
    logic [7:0]  ex;
    ex = f[30:23];
    r  = '0;
    s  = 1'b0;
    if (ex == 8'hFF && f[22:0] != '0) begin
      s = 1'b1;
      return;
    end
    if (ex == 8'hFF)      m = 1.0e40;
    else if (ex == 8'h00) m = 0.0;
    else m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (real'(int'(ex)) - 127.0));
    if (m >= 32768.0) begin
      r = f[31] ? 16'h8000 : 16'h7FFF;
      s = 1'b1;
    end else begin
      t = $rtoi(m);
      r = 16'(f[31] ? -t : t);
    end
  endfunction

  function automatic logic [31:0] rand_word();
    logic sg;
    sg = 1'($urandom);
    case ($urandom_range(0, 9))
      0:       return {sg, 8'hFF, 23'($urandom_range(1, 8388607))};
      1:       return {sg, 8'hFF, 23'h0};
      2:       return {sg, 8'h00, 23'($urandom)};
      3:       return {sg, 8'($urandom_range(140, 143)), 23'($urandom)};
      default: return {sg, 8'($urandom_range(118, 142)), 23'($urandom)};
    endcase
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin
          val_v[k] = (k == 0) && (tbl_idx < 9);
          val_d[k] = (k == 0 && tbl_idx < 9) ? tbl[tbl_idx] : 32'h0;
        end
        1: begin
          if (granted[k] || !val_v[k]) begin
            val_v[k] = ($urandom_range(0, 2) != 0);
            val_d[k] = rand_word();
          end else if ($urandom_range(0, 7) == 0) begin
            val_v[k] = 1'b0;
          end
        end
        default: begin
          if (granted[k] || !val_v[k]) begin
            val_v[k] = 1'b1;
            val_d[k] = rand_word();
          end
        end
      endcase
      req_valid[k]         = val_v[k];
      req_data[32*k +: 32] = val_d[k];
    end
    granted = '0;
    case (mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      3:       out_ready = (bp_cnt >= 10);
      4:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic sample();
    logic [N-1:0] exp_rdy;
    bit           exp_vld;
    int           g;
    exp_t         e;
    exp_vld = pend && (cyc - gnt_cyc >= 2);
    chk("out_valid", out_valid, exp_vld);
    chk("busy", busy, pend);
    if (exp_vld) begin
      chk("out_data", out_data, q[0].d);
      chk("out_id", out_id, q[0].id);
      chk("out_sat", out_sat, q[0].s);
    end
    exp_rdy = '0;
    g = -1;
    if (!pend) begin
      for (int i = 0; i < N; i++) begin
        int c;
        c = (rr + i) % N;
        if (g < 0 && val_v[c]) g = c;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (exp_vld && out_ready) begin
      if (mode == 0 && dir_acc < 9) begin
        chk("tbl_data", out_data, tbl_exp[dir_acc]);
        chk("tbl_sat", out_sat, tbl_sat[dir_acc]);
        dir_acc++;
      end
      void'(q.pop_front());
      pend   = 0;
      bp_cnt = 0;
    end else if (exp_vld) begin
      bp_cnt++;
    end
    if (g >= 0) begin
      pend    = 1;
      gnt_cyc = cyc;
      rr      = (g + 1) % N;
      ref_conv(val_d[g], e.d, e.s);
      e.id = g;
      q.push_back(e);
      granted[g] = 1'b1;
      if (mode == 0) tbl_idx++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    sample();
  endtask

  initial begin
    bit seen;
    for (int k = 0; k < N; k++) begin
      val_v[k] = 1'b0;
      val_d[k] = '0;
    end
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_id", out_id, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    mode = 0;
    for (int i = 0; i < 100 && dir_acc < 9; i++) cycle();
    chk("dir_done", dir_acc, 9);

    mode = 2;
    repeat (30) cycle();
    mode = 3;
    repeat (60) cycle();
    mode = 1;
    repeat (2000) cycle();

    mode = 4;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = out_valid;
    end
    chk("rst_wait_valid", seen, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", req_ready, 0);
    pend    = 0;
    rr      = 0;
    bp_cnt  = 0;
    granted = '0;
    q.delete();
    mode = 2;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc++;
    drive();
    @(negedge clk);
    chk("rst_first_gnt", req_ready, 2'b01);
    sample();
    repeat (20) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/float2int16_arbiter.md
Name: float2int16_arbiter

Overview:
- Shares one float32-to-int16 conversion datapath between NUM_REQ sample producers, e.g. the L/R channel outputs of the float DSP chain.
- Round-robin arbitration on valid/ready request ports.
- Conversion is truncating with defined saturation and NaN handling.
- Results are emitted one at a time on a valid/ready output, tagged with the source ID, toward the PCM/DAC serializer.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- SAT_EN, 1, 1 = clamp out-of-range magnitudes to +32767/-32768; 0 = force the exponent to 14 (mantissa-only result).
- IDW, $clog2(NUM_REQ) (min 1), width of the requester ID.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester sample valid.
- i_req_data  in  32*NUM_REQ  packed IEEE-754 single samples; requester k occupies bits [32k+31:32k].
- o_req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- o_out_valid  out  1  converted sample valid.
- i_out_ready  in  1  downstream accept.
- o_out_data  out  16  two's-complement int16 result.
- o_out_id  out  IDW  requester index of o_out_data.
- o_out_sat  out  1  result was clamped, forced, or NaN-zeroed.
- o_busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release) clears:
  - State to IDLE; rr_ptr to 0.
  - o_out_valid, o_out_data, o_out_id, o_out_sat, o_busy all 0.
  - o_req_ready all 0.
- FSM states: IDLE -> CONV -> OUT -> IDLE.
- IDLE:
  - If any i_req_valid is set, grant the first set requester scanning upward from rr_ptr, with wrap.
  - o_req_ready[g] = 1 combinationally in this cycle only.
  - Latch i_req_data[g] and g; set rr_ptr = g+1 mod NUM_REQ; go to CONV.
  - With no valid requester, stay in IDLE with o_req_ready = 0.
- CONV:
  - Apply the conversion to the latched word.
  - Register data, id and sat into the output regs; set o_out_valid = 1; go to OUT.
- OUT:
  - Hold o_out_valid and all output fields stable until i_out_ready = 1.
  - On the accept edge, clear o_out_valid and go to IDLE.
- Latency and throughput:
  - Grant to o_out_valid is 2 cycles.
  - Maximum throughput is one sample per 3 cycles with i_out_ready held at 1.
  - o_req_ready is never asserted while in CONV or OUT (no skid buffer).
- Conversion. Let e = exp[30:23] - 127, signed 9-bit:
  - exp = 255 with mantissa != 0 (NaN): result 0, sat = 1.
  - e < 0, including zero and denormals: magnitude 0, result 0 (never -0 / 0xFFFF), sat = 0.
  - 0 <= e <= 14: mag = {1'b1, mant[22:9]} >> (14-e), a 15-bit truncation toward zero.
  - e >= 15, including ±inf:
    - SAT_EN = 1: result 0x7FFF if sign = 0, else 0x8000; sat = 1.
    - SAT_EN = 0: treat e as 14; sat = 1.
  - Sign handling (e <= 14 and the SAT_EN = 0 forced case): result = sign ? -{1'b0, mag} : {1'b0, mag}.
- Boundaries:
  - A requester dropping valid before its grant is legal and is simply skipped.
  - A requester that holds valid after its grant is served again only after the other valid requesters, i.e. round-robin is fair.
  - Reset mid-CONV/OUT discards the sample; no o_out_valid glitch.

Decomposition:
- Package f2i_pkg:
  - State enum (IDLE, CONV, OUT).
  - Constants: EXP_BIAS = 127, INT16_MAX = 16'h7FFF, INT16_MIN = 16'h8000, MANT_KEEP = 14.
- Combinational sub-module float32_to_int16_sat.
  - Ports: float in, SAT_EN parameter, int16 out, sat out.
  - Instantiated once in the arbiter; reusable elsewhere.

Test Plan:
- Single requester 0 sends 0x3F800000 (1.0), then 0x43000000 (128.0), then 0xC0200000 (-2.5).
  - Outputs 0x0001, 0x0080, 0xFFFE; id = 0; sat = 0.
  - Each o_out_valid appears exactly 2 cycles after its grant.
- Edge values 0x3F000000 (0.5), 0x80000000 (-0.0), 0x46FFFE00 (32767.0).
  - Outputs 0x0000, 0x0000, 0x7FFF; sat = 0 for all.
- Out-of-range and NaN with SAT_EN = 1: 0x47000000 (32768.0), 0xFF800000 (-inf), 0x7FC00000 (NaN).
  - Outputs 0x7FFF, 0x8000, 0x0000; sat = 1 for all.
- Both requesters valid continuously from reset.
  - Grants alternate 0, 1, 0, 1.
  - o_out_id follows the same order.
  - o_req_ready is never asserted in CONV/OUT.
- Backpressure: i_out_ready = 0 for 10 cycles after o_out_valid.
  - Output fields stay constant; no new grant occurs.
  - After a 1-cycle accept, o_out_valid drops and the next grant follows in IDLE.
- Assert i_rst_n = 0 during OUT.
  - o_out_valid drops asynchronously to 0 and rr_ptr returns to 0.
  - After release, with both requesters valid, requester 0 is granted first.
